usb_reg_frontend: RTL

USB_REG_FRONTEND -- requirements
Module: usb_reg_frontend

---
 rtl/usb_reg_frontend.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/usb_reg_frontend.sv
// rtl/usb_reg_frontend.sv - USB controller parallel bus to internal register strobe frontend
//
// Turns the asynchronous cwusb_* strobes into synchronous reg_read/reg_write pulses
// and keeps a byte counter for multi-byte bursts to one address.
//
// Ports:
//   cwusb_clk, reset_n                 clock, synchronous active-low reset
//   cwusb_din / cwusb_dout             write data in / read data out (dout = reg_datai)
//   cwusb_isout                        bus output-enable (read in progress | I_drive_data)
//   cwusb_addr                         register address from the controller
//   cwusb_rdn, cwusb_wrn, cwusb_cen    active-low async strobes
//   I_drive_data                       forces cwusb_isout high
//   reg_address, reg_bytecnt           registered address, byte index within burst
//   reg_datao / reg_datai              write data out / read data in
//   reg_read, reg_write                one-cycle access pulses
//   reg_addrvalid                      high while an access is in progress

module usb_reg_frontend #(
    parameter int pADDR_WIDTH   = 8,
    parameter int pBYTECNT_SIZE = 7,
    parameter int pRD_HOLD      = 2,
    parameter int pBCNT_WRAP    = 1
) (
    input  logic                     cwusb_clk,
    input  logic                     reset_n,
    input  logic [7:0]               cwusb_din,
    output logic [7:0]               cwusb_dout,
    output logic                     cwusb_isout,
    input  logic [pADDR_WIDTH-1:0]   cwusb_addr,
    input  logic                     cwusb_rdn,
    input  logic                     cwusb_wrn,
    input  logic                     cwusb_cen,
    input  logic                     I_drive_data,
    output logic [pADDR_WIDTH-1:0]   reg_address,
    output logic [pBYTECNT_SIZE-1:0] reg_bytecnt,
    output logic [7:0]               reg_datao,
    input  logic [7:0]               reg_datai,
    output logic                     reg_read,
    output logic                     reg_write,
    output logic                     reg_addrvalid
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD      = 2'd1,
        ST_RD_HOLD = 2'd2,
        ST_WR      = 2'd3
    } state_t;

    localparam logic [3:0]               HOLD_INIT = 4'(pRD_HOLD);
    localparam logic [pBYTECNT_SIZE-1:0] BCNT_ONE  = {{(pBYTECNT_SIZE-1){1'b0}}, 1'b1};

    // Two-flop synchronizers; idle level of the strobes is 1.
    logic rdn_meta_q, rdn_s_q;
    logic wrn_meta_q, wrn_s_q;
    logic cen_meta_q, cen_s_q;

    state_t                     state_q, state_d;
    logic [3:0]                 hold_cnt_q, hold_cnt_d;
    logic [pADDR_WIDTH-1:0]     addr_q, addr_d;
    logic [pBYTECNT_SIZE-1:0]   bytecnt_q, bytecnt_d;
    logic [7:0]                 datao_q, datao_d;
    logic                       read_q, read_d;
    logic                       write_q, write_d;
    logic                       rd_done_q, rd_done_d;
    logic                       isout_q, isout_d;
    logic                       addrvalid_q, addrvalid_d;

    logic rd_act, wr_act;

    assign rd_act = ~cen_s_q & ~rdn_s_q;
    assign wr_act = ~cen_s_q & ~wrn_s_q;

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        addr_d     = addr_q;
        datao_d    = datao_q;
        read_d     = 1'b0;
        write_d    = 1'b0;
        rd_done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                addr_d = cwusb_addr;
                if (rd_act) begin
                    state_d = ST_RD;
                    read_d  = 1'b1;
                end else if (wr_act) begin
                    state_d = ST_WR;
                    datao_d = cwusb_din;
                end
            end
            ST_RD: begin
                // A concurrent wr_act is ignored: the read runs to completion.
                if (!rd_act) begin
                    rd_done_d = 1'b1;
                    if (pRD_HOLD == 0) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d    = ST_RD_HOLD;
                        hold_cnt_d = HOLD_INIT;
                    end
                end
            end
            ST_RD_HOLD: begin
                // A new read inside the hold window keeps the bus driven with no gap.
                if (rd_act) begin
                    state_d    = ST_RD;
                    read_d     = 1'b1;
                    hold_cnt_d = 4'd0;
                end else if (hold_cnt_q <= 4'd1) begin
                    state_d    = ST_IDLE;
                    hold_cnt_d = 4'd0;
                end else begin
                    hold_cnt_d = hold_cnt_q - 4'd1;
                end
            end
            ST_WR: begin
                if (wr_act) begin
                    datao_d = cwusb_din;
                end else begin
                    write_d = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Address change clears the burst counter and wins over a pending increment.
        bytecnt_d = bytecnt_q;
        if (state_q == ST_IDLE && cwusb_addr != addr_q) begin
            bytecnt_d = '0;
        end else if (rd_done_q || write_q) begin
            if (&bytecnt_q) begin
                bytecnt_d = (pBCNT_WRAP != 0) ? '0 : bytecnt_q;
            end else begin
                bytecnt_d = bytecnt_q + BCNT_ONE;
            end
        end

        isout_d     = (state_d == ST_RD) || (state_d == ST_RD_HOLD);
        addrvalid_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge cwusb_clk) begin
        if (!reset_n) begin
            rdn_meta_q  <= 1'b1;
            rdn_s_q     <= 1'b1;
            wrn_meta_q  <= 1'b1;
            wrn_s_q     <= 1'b1;
            cen_meta_q  <= 1'b1;
            cen_s_q     <= 1'b1;
            state_q     <= ST_IDLE;
            hold_cnt_q  <= 4'd0;
            addr_q      <= '0;
            bytecnt_q   <= '0;
            datao_q     <= 8'd0;
            read_q      <= 1'b0;
            write_q     <= 1'b0;
            rd_done_q   <= 1'b0;
            isout_q     <= 1'b0;
            addrvalid_q <= 1'b0;
        end else begin
            rdn_meta_q  <= cwusb_rdn;
            rdn_s_q     <= rdn_meta_q;
            wrn_meta_q  <= cwusb_wrn;
            wrn_s_q     <= wrn_meta_q;
            cen_meta_q  <= cwusb_cen;
            cen_s_q     <= cen_meta_q;
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            addr_q      <= addr_d;
            bytecnt_q   <= bytecnt_d;
            datao_q     <= datao_d;
            read_q      <= read_d;
            write_q     <= write_d;
            rd_done_q   <= rd_done_d;
            isout_q     <= isout_d;
            addrvalid_q <= addrvalid_d;
        end
    end

    assign cwusb_dout    = reg_datai;
    assign cwusb_isout   = isout_q | I_drive_data;
    assign reg_address   = addr_q;
    assign reg_bytecnt   = bytecnt_q;
    assign reg_datao     = datao_q;
    assign reg_read      = read_q;
    assign reg_write     = write_q;
    assign reg_addrvalid = addrvalid_q;

endmodule
